// File: rtl/fv_bank_arbiter.sv
// Feature-vector bank arbiter: each free bank grants one of the PE read requesters that
// target it, chosen round-robin. Each grant becomes a registered one-cycle command toward
// that bank's controller. Per-bank occupancy is tracked from the controllers' busy flags.
module fv_bank_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                enable_i,
  input  logic [NUM_REQ-1:0]                                  req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]                           req_addr_i,
  input  logic [NUM_REQ*TAG_W-1:0]                            req_tag_i,
  output logic [NUM_REQ-1:0]                                  req_ready_o,
  input  logic [NUM_BANKS-1:0]                                bank_busy_i,
  output logic [NUM_BANKS-1:0]                                bank_valid_o,
  output logic [NUM_BANKS*(ADDR_W-$clog2(NUM_BANKS))-1:0]     bank_addr_o,
  output logic [NUM_BANKS*TAG_W-1:0]                          bank_tag_o,
  output logic [CNT_W-1:0]                                    grant_count_o
);

  localparam int unsigned BankW = $clog2(NUM_BANKS);
  localparam int unsigned InW   = ADDR_W - BankW;
  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PopW  = $clog2(NUM_REQ + 1);
  localparam int unsigned SumW  = CNT_W + PopW;

  // LOCK covers the command cycle, before the controller has had a chance to raise busy.
  localparam logic [1:0] StAvail = 2'd0;
  localparam logic [1:0] StLock  = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;

  logic [1:0]           state_q  [NUM_BANKS];
  logic [1:0]           state_d  [NUM_BANKS];
  logic [PtrW-1:0]      rr_ptr_q [NUM_BANKS];
  logic [PtrW-1:0]      rr_ptr_d [NUM_BANKS];
  logic [PtrW-1:0]      gnt_idx  [NUM_BANKS];
  logic [NUM_BANKS-1:0] found;
  logic [NUM_BANKS-1:0] bank_gnt;

  logic [BankW-1:0]     req_bank   [NUM_REQ];
  logic [InW-1:0]       req_inaddr [NUM_REQ];
  logic [TAG_W-1:0]     req_tag    [NUM_REQ];

  logic [NUM_BANKS-1:0]       bank_valid_q, bank_valid_d;
  logic [NUM_BANKS*InW-1:0]   bank_addr_q,  bank_addr_d;
  logic [NUM_BANKS*TAG_W-1:0] bank_tag_q,   bank_tag_d;
  logic [CNT_W-1:0]           count_q,      count_d;
  logic [PopW-1:0]            pop;
  logic [SumW-1:0]            cnt_sum;

  // Split each request into target bank (top address bits), in-bank address and tag.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bank[i]   = req_addr_i[i*ADDR_W + ADDR_W - 1 -: BankW];
      req_inaddr[i] = req_addr_i[i*ADDR_W +: InW];
      req_tag[i]    = req_tag_i[i*TAG_W +: TAG_W];
    end
  end

  // Per-bank round-robin pick: first valid requester for this bank at or after the pointer.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    bank_gnt    = '0;
    found       = '0;
    req_ready_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_idx[b] = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_ptr_q[b]) + k) % NUM_REQ;
        if (!found[b] && req_valid_i[idx] && (req_bank[idx] == BankW'(b))) begin
          found[b]   = 1'b1;
          gnt_idx[b] = PtrW'(idx);
        end
      end
      // rst_ni gating keeps req_ready low for the whole time reset is held.
      if (found[b] && rst_ni && enable_i && !bank_busy_i[b] && (state_q[b] == StAvail)) begin
        bank_gnt[b]             = 1'b1;
        req_ready_o[gnt_idx[b]] = 1'b1;
      end
    end
  end

  // Bank occupancy FSM and pointer advance past the winner.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b]  = state_q[b];
      rr_ptr_d[b] = rr_ptr_q[b];
      case (state_q[b])
        StAvail: if (bank_gnt[b]) state_d[b] = StLock;
        StLock:  state_d[b] = bank_busy_i[b] ? StBusy : StAvail;
        StBusy:  if (!bank_busy_i[b]) state_d[b] = StAvail;
        default: state_d[b] = StAvail;
      endcase
      if (bank_gnt[b]) begin
        rr_ptr_d[b] = (gnt_idx[b] == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx[b] + 1'b1;
      end
    end
  end

  // Command payload for next cycle; zero on banks that did not grant.
  always_comb begin
    bank_valid_d = bank_gnt;
    bank_addr_d  = '0;
    bank_tag_d   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) begin
        bank_addr_d[b*InW +: InW]    = req_inaddr[gnt_idx[b]];
        bank_tag_d[b*TAG_W +: TAG_W] = req_tag[gnt_idx[b]];
      end
    end
  end

  // Saturating count of accepted requests; the sum is widened so overflow is visible.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop = pop + PopW'(req_valid_i[i] & req_ready_o[i]);
    end
    cnt_sum = SumW'(count_q) + SumW'(pop);
    if (|cnt_sum[SumW-1:CNT_W]) begin
      count_d = '1;
    end else begin
      count_d = cnt_sum[CNT_W-1:0];
    end
  end

  // State registers; reset drops any in-flight command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]  <= StAvail;
        rr_ptr_q[b] <= '0;
      end
      bank_valid_q <= '0;
      bank_addr_q  <= '0;
      bank_tag_q   <= '0;
      count_q      <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]  <= state_d[b];
        // Pointers hold while disabled because no grant can occur.
        rr_ptr_q[b] <= rr_ptr_d[b];
      end
      bank_valid_q <= bank_valid_d;
      bank_addr_q  <= bank_addr_d;
      bank_tag_q   <= bank_tag_d;
      count_q      <= count_d;
    end
  end

  assign bank_valid_o  = bank_valid_q;
  assign bank_addr_o   = bank_addr_q;
  assign bank_tag_o    = bank_tag_q;
  assign grant_count_o = count_q;

endmodule

// File: tb/tb_fv_bank_arbiter.sv
// Bench for fv_bank_arbiter: per-scenario tasks with inline checks, plus a command
// scoreboard filled when an acceptance is expected and drained when bank_valid appears.
module tb_fv_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [7:0]  req_tag;
  logic [3:0]  busy;
  logic [3:0]  req_ready,  req_ready_s;
  logic [3:0]  bank_valid, bank_valid_s;
  logic [23:0] bank_addr,  bank_addr_s;
  logic [7:0]  bank_tag,   bank_tag_s;
  logic [15:0] gcount;
  logic [1:0]  gcount_s;

  typedef struct packed {
    logic [1:0] bank;
    logic [5:0] addr;
    logic [1:0] tag;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  fv_bank_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_tag_i(req_tag),
    .req_ready_o(req_ready), .bank_busy_i(busy), .bank_valid_o(bank_valid),
    .bank_addr_o(bank_addr), .bank_tag_o(bank_tag), .grant_count_o(gcount)
  );

  // Narrow counter copy on the same stimulus, for saturation.
  fv_bank_arbiter #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_tag_i(req_tag),
    .req_ready_o(req_ready_s), .bank_busy_i(busy), .bank_valid_o(bank_valid_s),
    .bank_addr_o(bank_addr_s), .bank_tag_o(bank_tag_s), .grant_count_o(gcount_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [1:0] t);
    req_valid[i]       = 1'b1;
    req_addr[i*8 +: 8] = a;
    req_tag[i*2 +: 2]  = t;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic push(input logic [1:0] b, input logic [5:0] a, input logic [1:0] t);
    cmd_t c;
    c.bank = b; c.addr = a; c.tag = t;
    exp_q.push_back(c);
  endtask

  // Move to the falling edge and retire every command the banks present there.
  task automatic sample();
    cmd_t e;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (bank_valid[b]) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL cmd_unexpected: bank %0d got addr %h tag %0d, required none",
                   b, bank_addr[b*6 +: 6], bank_tag[b*2 +: 2]);
        end else begin
          e = exp_q.pop_front();
          if (e.bank != 2'(b) || e.addr !== bank_addr[b*6 +: 6] || e.tag !== bank_tag[b*2 +: 2])
          begin
            n_err++;
            $display("FAIL cmd_payload: got bank %0d addr %h tag %0d, required bank %0d addr %h tag %0d",
                     b, bank_addr[b*6 +: 6], bank_tag[b*2 +: 2], e.bank, e.addr, e.tag);
          end
        end
      end else if (bank_addr[b*6 +: 6] !== 6'h0 || bank_tag[b*2 +: 2] !== 2'h0) begin
        n_err++;
        $display("FAIL cmd_idle_zero: bank %0d got addr %h tag %0d, required 0/0",
                 b, bank_addr[b*6 +: 6], bank_tag[b*2 +: 2]);
      end
    end
  endtask

  task automatic test_reset();
    set_req(0, 8'h85, 2'd2);
    #2;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++;
      $display("FAIL reset_ready: got %b required 0000", req_ready); end
    n_cmp++; if (bank_valid !== 4'b0 || bank_addr !== 24'h0 || bank_tag !== 8'h0) begin n_err++;
      $display("FAIL reset_cmd: got v=%b a=%h t=%h required all 0", bank_valid, bank_addr, bank_tag);
    end
    n_cmp++; if (gcount !== 16'd0 || gcount_s !== 2'd0) begin n_err++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", gcount, gcount_s); end
    repeat (2) step();
    n_cmp++; if (req_ready !== 4'b0 || bank_valid !== 4'b0) begin n_err++;
      $display("FAIL reset_held: got ready %b valid %b required 0000/0000", req_ready, bank_valid);
    end
    clr_req(0);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 8'h85, 2'd2);
    sample();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL single_ready: got %b required 0001", req_ready); end
    push(2'd2, 6'h05, 2'd2); exp_cnt++;
    step(); clr_req(0); set_req(1, 8'h8A, 2'd1);
    sample();
    n_cmp++; if (bank_valid !== 4'b0100) begin n_err++;
      $display("FAIL single_bank_valid: got %b required 0100", bank_valid); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++;
      $display("FAIL single_lock_block: got %b required 0000", req_ready); end
    step();
    sample();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++;
      $display("FAIL single_after_lock: got %b required 0010", req_ready); end
    push(2'd2, 6'h0A, 2'd1); exp_cnt++;
    step(); clr_req(1);
    sample();
    step();
    sample();
    n_cmp++; if (bank_valid !== 4'b0000) begin n_err++;
      $display("FAIL single_idle: got %b required 0000", bank_valid); end
    n_cmp++; if (gcount !== 16'(exp_cnt)) begin n_err++;
      $display("FAIL single_count: got %0d required %0d", gcount, exp_cnt); end
    step();
  endtask

  task automatic test_contention();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) set_req(i, 8'h40 + 8'(i), 2'(i));
    for (int g = 0; g < 4; g++) begin
      m = 4'b0001 << g;
      sample();
      n_cmp++; if (req_ready !== m) begin n_err++;
        $display("FAIL contention_grant%0d: got %b required %b", g, req_ready, m); end
      push(2'd1, 6'(g), 2'(g)); exp_cnt++;
      step(); clr_req(g);
      sample();
      n_cmp++; if (req_ready !== 4'b0000 || bank_valid !== 4'b0010) begin n_err++;
        $display("FAIL contention_lock%0d: got ready %b valid %b required 0000/0010",
                 g, req_ready, bank_valid);
      end
      step();
    end
    sample();
    n_cmp++; if (gcount !== 16'(exp_cnt)) begin n_err++;
      $display("FAIL contention_count: got %0d required %0d", gcount, exp_cnt); end
    step();
  endtask

  task automatic test_parallel();
    for (int i = 0; i < 4; i++) set_req(i, {2'(i), 6'(i + 3)}, 2'(i));
    sample();
    n_cmp++; if (req_ready !== 4'b1111) begin n_err++;
      $display("FAIL parallel_ready: got %b required 1111", req_ready); end
    for (int i = 0; i < 4; i++) begin push(2'(i), 6'(i + 3), 2'(i)); exp_cnt++; end
    step(); req_valid = 4'b0;
    sample();
    n_cmp++; if (bank_valid !== 4'b1111) begin n_err++;
      $display("FAIL parallel_valid: got %b required 1111", bank_valid); end
    step();
  endtask

  task automatic test_busy();
    set_req(1, 8'h11, 2'd1);
    sample();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++;
      $display("FAIL busy_first: got %b required 0010", req_ready); end
    push(2'd0, 6'h11, 2'd1); exp_cnt++;
    step(); clr_req(1); set_req(2, 8'h22, 2'd2);
    sample();
    n_cmp++; if (req_ready !== 4'b0000 || bank_valid !== 4'b0001) begin n_err++;
      $display("FAIL busy_lock: got ready %b valid %b required 0000/0001", req_ready, bank_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step(); busy[0] = 1'b1;
      sample();
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++;
        $display("FAIL busy_hold%0d: got %b required 0000", k, req_ready); end
    end
    step(); busy[0] = 1'b0;
    sample();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++;
      $display("FAIL busy_regrant: got %b required 0100", req_ready); end
    push(2'd0, 6'h22, 2'd2); exp_cnt++;
    // Busy raised during LOCK moves the bank to BUSY, which needs one idle cycle to leave.
    step(); clr_req(2); set_req(3, 8'h33, 2'd3); busy[0] = 1'b1;
    sample();
    step();
    sample();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++;
      $display("FAIL busy_state: got %b required 0000", req_ready); end
    step(); busy[0] = 1'b0;
    sample();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++;
      $display("FAIL busy_exit_cycle: got %b required 0000", req_ready); end
    step();
    sample();
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++;
      $display("FAIL busy_after_exit: got %b required 1000", req_ready); end
    push(2'd0, 6'h33, 2'd3); exp_cnt++;
    step(); clr_req(3);
    sample();
    n_cmp++; if (gcount !== 16'(exp_cnt)) begin n_err++;
      $display("FAIL busy_count: got %0d required %0d", gcount, exp_cnt); end
    step();
  endtask

  task automatic test_enable();
    enable = 1'b0;
    set_req(0, 8'hC7, 2'd3);
    for (int k = 0; k < 3; k++) begin
      sample();
      n_cmp++; if (req_ready !== 4'b0000 || bank_valid !== 4'b0000) begin n_err++;
        $display("FAIL enable_block%0d: got ready %b valid %b required 0000/0000",
                 k, req_ready, bank_valid);
      end
      step();
    end
    enable = 1'b1;
    sample();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL enable_grant: got %b required 0001", req_ready); end
    push(2'd3, 6'h07, 2'd3); exp_cnt++;
    step(); clr_req(0);
    sample();
    n_cmp++; if (bank_valid !== 4'b1000) begin n_err++;
      $display("FAIL enable_valid: got %b required 1000", bank_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    set_req(2, 8'h05, 2'd2);
    sample();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++;
      $display("FAIL mid_grant0: got %b required 0100", req_ready); end
    push(2'd0, 6'h05, 2'd2); exp_cnt++;
    step(); clr_req(2); busy[0] = 1'b1; set_req(1, 8'h4F, 2'd1);
    sample();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++;
      $display("FAIL mid_grant1: got %b required 0010", req_ready); end
    exp_cnt++;
    step(); clr_req(1);
    // Bank0 is now BUSY and bank1 is presenting its command.
    n_cmp++; if (bank_valid !== 4'b0010 || bank_addr[11:6] !== 6'h0F) begin n_err++;
      $display("FAIL mid_pre_valid: got %b/%h required 0010/0f", bank_valid, bank_addr[11:6]);
    end
    n_cmp++; if (gcount !== 16'(exp_cnt) || gcount_s !== 2'd3) begin n_err++;
      $display("FAIL mid_pre_count: got %0d/%0d required %0d/3", gcount, gcount_s, exp_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bank_valid !== 4'b0 || bank_addr !== 24'h0 || bank_tag !== 8'h0) begin n_err++;
      $display("FAIL mid_reset_cmd: got v=%b a=%h t=%h required all 0",
               bank_valid, bank_addr, bank_tag);
    end
    n_cmp++; if (gcount !== 16'd0 || gcount_s !== 2'd0 || req_ready !== 4'b0) begin n_err++;
      $display("FAIL mid_reset_state: got %0d/%0d ready %b required 0/0/0000",
               gcount, gcount_s, req_ready);
    end
    sample();
    step(); rst_n = 1'b1; busy = 4'b0; exp_cnt = 0;
    for (int i = 0; i < 4; i++) set_req(i, {2'(i), 6'(i + 16)}, 2'(i));
    sample();
    n_cmp++; if (req_ready !== 4'b1111) begin n_err++;
      $display("FAIL mid_restart: got %b required 1111", req_ready); end
    for (int i = 0; i < 4; i++) begin push(2'(i), 6'(i + 16), 2'(i)); exp_cnt++; end
    step(); req_valid = 4'b0;
    sample();
    n_cmp++; if (gcount !== 16'd4 || gcount_s !== 2'd3) begin n_err++;
      $display("FAIL sat_four: got %0d/%0d required 4/3", gcount, gcount_s); end
    step(); set_req(0, 8'h40, 2'd0);
    sample();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL sat_fifth_ready: got %b required 0001", req_ready); end
    push(2'd1, 6'h00, 2'd0); exp_cnt++;
    step(); clr_req(0);
    sample();
    n_cmp++; if (gcount !== 16'(exp_cnt) || gcount_s !== 2'd3) begin n_err++;
      $display("FAIL sat_five: got %0d/%0d required %0d/3", gcount, gcount_s, exp_cnt); end
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; busy = 4'b0;
    req_valid = 4'b0; req_addr = 32'h0; req_tag = 8'h0;
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_busy();
    test_enable();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
